// File: rtl/onchip_mem_dma_engine_if.sv
// CSR slave and on-chip RAM master signal bundle for onchip_mem_dma_engine.
// slave = the engine side; master = host CPU plus RAM side.
interface onchip_mem_dma_engine_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  logic [2:0]        csr_address;
  logic              csr_chipselect;
  logic              csr_write;
  logic              csr_read;
  logic [31:0]       csr_writedata;
  logic [31:0]       csr_readdata;
  logic              irq;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  csr_address, csr_chipselect, csr_write, csr_read, csr_writedata, mem_readdata,
    output csr_readdata, irq, mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken
  );

  modport master (
    output csr_address, csr_chipselect, csr_write, csr_read, csr_writedata, mem_readdata,
    input  csr_readdata, irq, mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_mem_dma_engine.sv
// FILL / CHECK / COPY block-transfer engine in front of the 2048x32 on-chip RAM.
// Optional ONCHIP_DMA_PATTERN_INC_EN: FILL/CHECK use PATTERN+i instead of a constant PATTERN.
module onchip_mem_dma_engine #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 12
) (
  input logic                    clk,
  input logic                    reset,
  onchip_mem_dma_engine_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StFill, StChkIssue, StChkDrain, StCpRd, StCpCap, StCpWr, StFinish
  } state_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(2 ** ADDR_W);
  localparam logic [11:0]      ErrMax = 12'hFFF;
`ifdef ONCHIP_DMA_PATTERN_INC_EN
  localparam logic [DATA_W-1:0] PatStep = DATA_W'(1);
`else
  localparam logic [DATA_W-1:0] PatStep = '0;
`endif

  state_e            state_q;
  logic [1:0]        op_q;
  logic              irq_en_q, busy_q, done_q, mismatch_q, aborted_q;
  logic [ADDR_W-1:0] src_q, dst_q, first_err_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [DATA_W-1:0] pattern_q, exp_q;
  logic [11:0]       errcnt_q;
  logic [ADDR_W-1:0] src_ptr_q, dst_ptr_q, pend_addr_q;
  logic              pend_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              cs_q, we_q;
  logic [DATA_W-1:0] wdata_q;

  logic              csr_wr, wr_ctrl, start, abort, cmp_en, mismatch_now;
  logic [1:0]        start_op;
  logic [LEN_W-1:0]  len_eff;
  logic [31:0]       rdata;

  assign csr_wr       = bus.csr_chipselect && bus.csr_write;
  assign wr_ctrl      = csr_wr && (bus.csr_address == 3'd0);
  assign start        = wr_ctrl && bus.csr_writedata[0] && !busy_q;
  assign abort        = wr_ctrl && bus.csr_writedata[3] && busy_q;
  assign start_op     = bus.csr_writedata[2:1];
  assign len_eff      = (len_q > MaxLen) ? MaxLen : len_q;
  // A read issued last cycle has its data on mem_readdata now.
  assign cmp_en       = pend_q && (state_q == StChkIssue || state_q == StChkDrain);
  assign mismatch_now = cmp_en && (bus.mem_readdata != exp_q);

  always_comb begin
    rdata = '0;
    case (bus.csr_address)
      3'd0:    rdata = {27'd0, irq_en_q, 1'b0, op_q, 1'b0};
      3'd1:    rdata = {28'd0, aborted_q, mismatch_q, done_q, busy_q};
      3'd2:    rdata = 32'(src_q);
      3'd3:    rdata = 32'(dst_q);
      3'd4:    rdata = 32'(len_q);
      3'd5:    rdata = 32'(pattern_q);
      3'd6:    rdata = 32'(errcnt_q);
      default: rdata = 32'(first_err_q);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      irq_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      aborted_q   <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      first_err_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pattern_q   <= '0;
      exp_q       <= '0;
      errcnt_q    <= '0;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      if (csr_wr) begin
        case (bus.csr_address)
          3'd0: begin
            op_q     <= bus.csr_writedata[2:1];
            irq_en_q <= bus.csr_writedata[4];
          end
          3'd1: begin
            if (bus.csr_writedata[1]) done_q     <= 1'b0;
            if (bus.csr_writedata[2]) mismatch_q <= 1'b0;
            if (bus.csr_writedata[3]) aborted_q  <= 1'b0;
          end
          3'd2: if (!busy_q) src_q     <= bus.csr_writedata[ADDR_W-1:0];
          3'd3: if (!busy_q) dst_q     <= bus.csr_writedata[ADDR_W-1:0];
          3'd4: if (!busy_q) len_q     <= bus.csr_writedata[LEN_W-1:0];
          3'd5: if (!busy_q) pattern_q <= bus.csr_writedata;
          default: ;
        endcase
      end

      if (bus.csr_chipselect && bus.csr_read) rdata_q <= rdata;

      if (cmp_en) begin
        exp_q <= exp_q + PatStep;
        if (mismatch_now) begin
          mismatch_q <= 1'b1;
          if (errcnt_q != ErrMax) errcnt_q <= errcnt_q + 12'd1;
          if (errcnt_q == '0) first_err_q <= pend_addr_q;
        end
      end

      if (abort) aborted_q <= 1'b1;

      // Hardware status sets come after the W1C handling so a same-cycle set wins.
      case (state_q)
        StFill: begin
          if (cnt_q == '0 || abort) begin
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            cnt_q      <= cnt_q - 1'b1;
            mem_addr_q <= mem_addr_q + 1'b1;
            wdata_q    <= wdata_q + PatStep;
          end
        end
        StChkIssue: begin
          pend_q      <= 1'b1;
          pend_addr_q <= mem_addr_q;
          if (cnt_q == '0 || abort) begin
            cs_q    <= 1'b0;
            state_q <= StChkDrain;
          end else begin
            cnt_q      <= cnt_q - 1'b1;
            mem_addr_q <= mem_addr_q + 1'b1;
          end
        end
        StChkDrain: begin
          pend_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StFinish;
        end
        StCpRd: begin
          cs_q <= 1'b0;
          if (abort) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            state_q <= StCpCap;
          end
        end
        StCpCap: begin
          if (abort) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            cs_q       <= 1'b1;
            we_q       <= 1'b1;
            mem_addr_q <= dst_ptr_q;
            wdata_q    <= bus.mem_readdata;
            state_q    <= StCpWr;
          end
        end
        StCpWr: begin
          we_q <= 1'b0;
          if (cnt_q == '0 || abort) begin
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            cnt_q      <= cnt_q - 1'b1;
            src_ptr_q  <= src_ptr_q + 1'b1;
            dst_ptr_q  <= dst_ptr_q + 1'b1;
            mem_addr_q <= src_ptr_q + 1'b1;
            state_q    <= StCpRd;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase

      // Only reachable from IDLE or FINISH since BUSY is low there.
      if (start) begin
        errcnt_q <= '0;
        if (start_op == 2'd3 || len_eff == '0) begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end else begin
          busy_q    <= 1'b1;
          cnt_q     <= len_eff - 1'b1;
          src_ptr_q <= src_q;
          dst_ptr_q <= dst_q;
          exp_q     <= pattern_q;
          pend_q    <= 1'b0;
          cs_q      <= 1'b1;
          case (start_op)
            2'd0: begin
              we_q       <= 1'b1;
              mem_addr_q <= dst_q;
              wdata_q    <= pattern_q;
              state_q    <= StFill;
            end
            2'd1: begin
              we_q       <= 1'b0;
              mem_addr_q <= src_q;
              state_q    <= StChkIssue;
            end
            default: begin
              we_q       <= 1'b0;
              mem_addr_q <= src_q;
              state_q    <= StCpRd;
            end
          endcase
        end
      end
    end
  end

  assign bus.csr_readdata   = rdata_q;
  assign bus.irq            = done_q & irq_en_q;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_write      = we_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_dma_engine.sv
// Scoreboard bench for onchip_mem_dma_engine: expected RAM accesses are queued when a
// transfer is started and popped by a monitor on every mem_chipselect cycle.
module tb_onchip_mem_dma_engine;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 12;
`ifdef ONCHIP_DMA_PATTERN_INC_EN
  localparam logic [31:0] PAT_STEP = 32'd1;
`else
  localparam logic [31:0] PAT_STEP = 32'd0;
`endif

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_op_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned wr_cnt = 0;
  mem_op_t     sb[$];
  logic [31:0] ram[2048];

  onchip_mem_dma_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_mem_dma_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model: synchronous write, read data valid one cycle after issue.
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) ram[bus.mem_address] = bus.mem_writedata;
      else bus.mem_readdata <= ram[bus.mem_address];
    end
  end

  always @(negedge clk) begin
    mem_op_t got, exp;
    if (!reset && bus.mem_chipselect) begin
      if (bus.mem_write) wr_cnt++;
      check_eq("mem_sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp      = sb.pop_front();
        got.we   = bus.mem_write;
        got.addr = bus.mem_address;
        got.data = bus.mem_write ? bus.mem_writedata : '0;
        check_eq("mem_op", 64'(got), 64'(exp));
      end
    end
  end

  task automatic push_fill(input logic [ADDR_W-1:0] dst, input int n, input logic [31:0] pat);
    mem_op_t op;
    for (int i = 0; i < n; i++) begin
      op.we = 1'b1; op.addr = dst + ADDR_W'(i); op.data = pat + PAT_STEP * 32'(i);
      sb.push_back(op);
    end
  endtask

  task automatic push_check(input logic [ADDR_W-1:0] src, input int n);
    mem_op_t op;
    for (int i = 0; i < n; i++) begin
      op.we = 1'b0; op.addr = src + ADDR_W'(i); op.data = '0;
      sb.push_back(op);
    end
  endtask

  task automatic push_copy(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                           input int n);
    mem_op_t op;
    for (int i = 0; i < n; i++) begin
      op.we = 1'b0; op.addr = src + ADDR_W'(i); op.data = '0;
      sb.push_back(op);
      op.we = 1'b1; op.addr = dst + ADDR_W'(i); op.data = ram[src + ADDR_W'(i)];
      sb.push_back(op);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    bus.csr_address    = a;
    bus.csr_writedata  = d;
    bus.csr_chipselect = 1'b1;
    bus.csr_write      = 1'b1;
    @(posedge clk); #1;
    bus.csr_chipselect = 1'b0;
    bus.csr_write      = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    bus.csr_address    = a;
    bus.csr_chipselect = 1'b1;
    bus.csr_read       = 1'b1;
    @(posedge clk); #1;
    bus.csr_chipselect = 1'b0;
    bus.csr_read       = 1'b0;
    d = bus.csr_readdata;
  endtask

  task automatic wait_irq(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!bus.irq && cycles < limit);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          cyc;
    bus.csr_address    = '0;
    bus.csr_chipselect = 1'b0;
    bus.csr_write      = 1'b0;
    bus.csr_read       = 1'b0;
    bus.csr_writedata  = '0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_irq", 64'(bus.irq), 64'd0);
    check_eq("rst_cs", 64'(bus.mem_chipselect), 64'd0);
    check_eq("rst_we", 64'(bus.mem_write), 64'd0);
    check_eq("rst_addr", 64'(bus.mem_address), 64'd0);
    check_eq("rst_wdata", 64'(bus.mem_writedata), 64'd0);
    check_eq("rst_rdata", 64'(bus.csr_readdata), 64'd0);
    check_eq("byteenable", 64'(bus.mem_byteenable), 64'hF);
    check_eq("clken", 64'(bus.mem_clken), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    csr_rd(3'd1, rd);
    check_eq("rst_status", 64'(rd), 64'd0);

    // FILL 0x010..0x013
    csr_wr(3'd3, 32'h010);
    csr_wr(3'd4, 32'd4);
    csr_wr(3'd5, 32'hA5A5A5A5);
    push_fill(11'h010, 4, 32'hA5A5A5A5);
    csr_wr(3'd0, 32'h11);
    wait_irq(50, cyc);
    check_eq("fill_latency", 64'(cyc), 64'd4);
    check_eq("fill_irq", 64'(bus.irq), 64'd1);
    csr_rd(3'd1, rd);
    check_eq("fill_status", 64'(rd), 64'h2);
    check_eq("fill_sb_drained", 64'(sb.size()), 64'd0);
    csr_wr(3'd1, 32'hE);
    check_eq("irq_cleared", 64'(bus.irq), 64'd0);

    // CHECK with one corrupted word
    ram[11'h012] = 32'h0;
    csr_wr(3'd2, 32'h010);
    push_check(11'h010, 4);
    csr_wr(3'd0, 32'h13);
    wait_irq(50, cyc);
    check_eq("chk_latency", 64'(cyc), 64'd5);
    csr_rd(3'd6, rd);
    check_eq("chk_errcnt", 64'(rd), 64'd1);
    csr_rd(3'd7, rd);
    check_eq("chk_first_err", 64'(rd), 64'h012);
    csr_rd(3'd1, rd);
    check_eq("chk_status", 64'(rd), 64'h6);
    check_eq("chk_sb_drained", 64'(sb.size()), 64'd0);
    csr_wr(3'd1, 32'hE);

    // COPY across the address wrap
    ram[11'h7FE] = 32'h11111111;
    ram[11'h7FF] = 32'h22222222;
    ram[11'h000] = 32'h33333333;
    ram[11'h001] = 32'h44444444;
    csr_wr(3'd2, 32'h7FE);
    csr_wr(3'd3, 32'h100);
    push_copy(11'h7FE, 11'h100, 4);
    csr_wr(3'd0, 32'h15);
    wait_irq(50, cyc);
    check_eq("copy_latency", 64'(cyc), 64'd12);
    check_eq("copy_w0", 64'(ram[11'h100]), 64'h11111111);
    check_eq("copy_w1", 64'(ram[11'h101]), 64'h22222222);
    check_eq("copy_w2", 64'(ram[11'h102]), 64'h33333333);
    check_eq("copy_w3", 64'(ram[11'h103]), 64'h44444444);
    check_eq("copy_sb_drained", 64'(sb.size()), 64'd0);
    csr_wr(3'd1, 32'hE);

    // ABORT two cycles into a long FILL
    csr_wr(3'd3, 32'h200);
    csr_wr(3'd4, 32'd100);
    csr_wr(3'd5, 32'hDEADBEEF);
    wr_cnt = 0;
    push_fill(11'h200, 3, 32'hDEADBEEF);
    csr_wr(3'd0, 32'h11);
    @(posedge clk); #1;
    csr_wr(3'd0, 32'h18);
    wait_irq(200, cyc);
    check_eq("abort_irq", 64'(bus.irq), 64'd1);
    csr_rd(3'd1, rd);
    check_eq("abort_status", 64'(rd), 64'hA);
    check_eq("abort_writes_le3", 64'(wr_cnt <= 3), 64'd1);
    check_eq("abort_writes_ge1", 64'(wr_cnt >= 1), 64'd1);
    sb.delete();
    csr_wr(3'd1, 32'hE);

    // START and LEN write while BUSY are ignored
    csr_wr(3'd3, 32'h300);
    csr_wr(3'd4, 32'd8);
    push_fill(11'h300, 8, 32'hDEADBEEF);
    csr_wr(3'd0, 32'h11);
    csr_wr(3'd0, 32'h15);
    csr_wr(3'd4, 32'd0);
    wait_irq(50, cyc);
    check_eq("busy_start_latency", 64'(cyc), 64'd6);
    csr_rd(3'd4, rd);
    check_eq("busy_len_kept", 64'(rd), 64'd8);
    csr_rd(3'd1, rd);
    check_eq("busy_status", 64'(rd), 64'h2);
    check_eq("busy_sb_drained", 64'(sb.size()), 64'd0);
    csr_wr(3'd1, 32'hE);

    // LEN=0 and OP=3 complete at once with no RAM access
    csr_wr(3'd4, 32'd0);
    csr_wr(3'd0, 32'h11);
    wait_irq(20, cyc);
    check_eq("len0_latency", 64'(cyc), 64'd1);
    csr_wr(3'd1, 32'hE);
    csr_wr(3'd4, 32'd4);
    csr_wr(3'd0, 32'h17);
    wait_irq(20, cyc);
    check_eq("op3_latency", 64'(cyc), 64'd1);
    csr_wr(3'd1, 32'hE);

    // LEN above 2048 saturates
    csr_wr(3'd3, 32'h7F0);
    csr_wr(3'd4, 32'hFFF);
    csr_wr(3'd5, 32'h0F0F0000);
    push_fill(11'h7F0, 2048, 32'h0F0F0000);
    csr_wr(3'd0, 32'h11);
    wait_irq(3000, cyc);
    check_eq("sat_latency", 64'(cyc), 64'd2048);
    check_eq("sat_sb_drained", 64'(sb.size()), 64'd0);
    csr_wr(3'd1, 32'hE);

    // Pattern near 32-bit wrap, then CHECK the same region
    csr_wr(3'd2, 32'h400);
    csr_wr(3'd3, 32'h400);
    csr_wr(3'd4, 32'd3);
    csr_wr(3'd5, 32'hFFFFFFFE);
    push_fill(11'h400, 3, 32'hFFFFFFFE);
    csr_wr(3'd0, 32'h11);
    wait_irq(50, cyc);
    check_eq("pat_fill_latency", 64'(cyc), 64'd3);
    csr_wr(3'd1, 32'hE);
    push_check(11'h400, 3);
    csr_wr(3'd0, 32'h13);
    wait_irq(50, cyc);
    check_eq("pat_chk_latency", 64'(cyc), 64'd4);
    csr_rd(3'd6, rd);
    check_eq("pat_errcnt", 64'(rd), 64'd0);
    csr_rd(3'd1, rd);
    check_eq("pat_status", 64'(rd), 64'h2);
    csr_wr(3'd1, 32'hE);

    // Reset in the middle of a transfer
    csr_wr(3'd3, 32'h500);
    csr_wr(3'd4, 32'd50);
    push_fill(11'h500, 50, 32'hFFFFFFFE);
    csr_wr(3'd0, 32'h11);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_cs", 64'(bus.mem_chipselect), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    check_eq("midrst_cs_after", 64'(bus.mem_chipselect), 64'd0);
    csr_rd(3'd1, rd);
    check_eq("midrst_status", 64'(rd), 64'd0);
    csr_rd(3'd4, rd);
    check_eq("midrst_len", 64'(rd), 64'd0);
    csr_rd(3'd0, rd);
    check_eq("midrst_ctrl", 64'(rd), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
